// File: rtl/uart16550_host.sv
`default_nettype none
// ============================================================================
// uart16550_host: Wishbone master that initialises a uart16550 and moves bytes
// between valid/ready streams and the THR/RBR registers.   Rev 1.0
// ============================================================================
module uart16550_host #(
   parameter logic [15:0] DIVISOR = 16'd27,
   parameter logic [7:0]  LCR_VAL = 8'h03,
   parameter logic [7:0]  FCR_VAL = 8'hC7
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   output logic [2:0] wbm_adr_o,
   output logic [7:0] wbm_dat_o,
   input  logic [7:0] wbm_dat_i,
   output logic       wbm_we_o,
   output logic       wbm_stb_o,
   output logic       wbm_cyc_o,
   output logic [3:0] wbm_sel_o,
   input  logic       wbm_ack_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       init_done_o,
   output logic       rx_overrun_o
);

   typedef enum logic [2:0] {
      S_INIT      = 3'd0,
      S_POLL      = 3'd1,
      S_DECIDE    = 3'd2,
      S_RD_RBR    = 3'd3,
      S_TX_ACCEPT = 3'd4,
      S_WR_THR    = 3'd5
   } state_t;

   state_t     r_state;
   logic [2:0] r_step;
   logic [2:0] r_lsr;       // {THRE, OE, DR}
   logic [7:0] r_tx_byte;
   logic [2:0] w_init_adr;
   logic [7:0] w_init_dat;
   logic       w_done;

   assign wbm_sel_o = 4'hF;
   assign w_done    = wbm_cyc_o & wbm_ack_i;

   always_comb begin
      w_init_adr = 3'd1;
      w_init_dat = 8'h00;
      case (r_step)
         3'd0: begin w_init_adr = 3'd3; w_init_dat = LCR_VAL | 8'h80; end
         3'd1: begin w_init_adr = 3'd0; w_init_dat = DIVISOR[7:0];    end
         3'd2: begin w_init_adr = 3'd1; w_init_dat = DIVISOR[15:8];   end
         3'd3: begin w_init_adr = 3'd3; w_init_dat = LCR_VAL & 8'h7F; end
         3'd4: begin w_init_adr = 3'd2; w_init_dat = FCR_VAL;         end
         default: ;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         r_state      <= S_INIT;
         r_step       <= 3'd0;
         r_lsr        <= 3'd0;
         r_tx_byte    <= 8'h00;
         wbm_adr_o    <= 3'd0;
         wbm_dat_o    <= 8'h00;
         wbm_we_o     <= 1'b0;
         wbm_stb_o    <= 1'b0;
         wbm_cyc_o    <= 1'b0;
         tx_ready_o   <= 1'b0;
         rx_data_o    <= 8'h00;
         rx_valid_o   <= 1'b0;
         init_done_o  <= 1'b0;
         rx_overrun_o <= 1'b0;
      end else begin
         tx_ready_o <= 1'b0;
         if (rx_valid_o && rx_ready_i)
            rx_valid_o <= 1'b0;
         // The edge after the ack always ends the cycle, guaranteeing an idle gap.
         if (w_done) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
         end

         case (r_state)
            S_INIT: begin
               if (!wbm_cyc_o) begin
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
                  wbm_we_o  <= 1'b1;
                  wbm_adr_o <= w_init_adr;
                  wbm_dat_o <= w_init_dat;
               end else if (w_done) begin
                  if (r_step == 3'd5) begin
                     init_done_o <= 1'b1;
                     r_state     <= S_POLL;
                  end else begin
                     r_step <= r_step + 3'd1;
                  end
               end
            end
            S_POLL: begin
               if (!wbm_cyc_o) begin
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
                  wbm_we_o  <= 1'b0;
                  wbm_adr_o <= 3'd5;
               end else if (w_done) begin
                  r_lsr   <= {wbm_dat_i[5], wbm_dat_i[1], wbm_dat_i[0]};
                  r_state <= S_DECIDE;
               end
            end
            S_DECIDE: begin
               if (r_lsr[1])
                  rx_overrun_o <= 1'b1;
               if (r_lsr[0] && !rx_valid_o) begin
                  r_state <= S_RD_RBR;
               end else if (r_lsr[2] && tx_valid_i) begin
                  tx_ready_o <= 1'b1;
                  r_state    <= S_TX_ACCEPT;
               end else begin
                  r_state <= S_POLL;
               end
            end
            S_RD_RBR: begin
               if (!wbm_cyc_o) begin
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
                  wbm_we_o  <= 1'b0;
                  wbm_adr_o <= 3'd0;
               end else if (w_done) begin
                  rx_data_o  <= wbm_dat_i;
                  rx_valid_o <= 1'b1;
                  r_state    <= S_POLL;
               end
            end
            S_TX_ACCEPT: begin
               r_tx_byte <= tx_data_i;
               r_state   <= S_WR_THR;
            end
            S_WR_THR: begin
               if (!wbm_cyc_o) begin
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
                  wbm_we_o  <= 1'b1;
                  wbm_adr_o <= 3'd0;
                  wbm_dat_o <= r_tx_byte;
               end else if (w_done) begin
                  r_state <= S_POLL;
               end
            end
            default: r_state <= S_INIT;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart16550_host.sv
`default_nettype none
// ============================================================================
// tb_uart16550_host: Wishbone slave model plus stream model for uart16550_host.
// Rev 1.0
// ============================================================================
module tb_uart16550_host;

   localparam logic [15:0] C_DIV = 16'd27;
   localparam logic [7:0]  C_LCR = 8'h03;
   localparam logic [7:0]  C_FCR = 8'hC7;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] adr;
   logic [7:0] wdat;
   logic [7:0] rdat;
   logic       we, stb, cyc, ack;
   logic [3:0] sel;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, rx_ready;
   logic       init_done, overrun;

   always #5 clk = ~clk;

   uart16550_host #(.DIVISOR(C_DIV), .LCR_VAL(C_LCR), .FCR_VAL(C_FCR)) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst_n),
      .wbm_adr_o   (adr),
      .wbm_dat_o   (wdat),
      .wbm_dat_i   (rdat),
      .wbm_we_o    (we),
      .wbm_stb_o   (stb),
      .wbm_cyc_o   (cyc),
      .wbm_sel_o   (sel),
      .wbm_ack_i   (ack),
      .tx_data_i   (tx_data),
      .tx_valid_i  (tx_valid),
      .tx_ready_o  (tx_ready),
      .rx_data_o   (rx_data),
      .rx_valid_o  (rx_valid),
      .rx_ready_i  (rx_ready),
      .init_done_o (init_done),
      .rx_overrun_o(overrun)
   );

   typedef struct packed { logic we; logic [2:0] adr; logic [7:0] dat; } txn_t;
   txn_t        log_q[$];
   int          ws = 0, grants = 0, served = 0, stab_err = 0, cnt = 0;
   logic [7:0]  lsr_val = 8'h00, rbr_val = 8'h00;
   logic        in_cyc = 1'b0;
   logic [11:0] cap = 12'h000;

   // Slave: ack after ws wait states; LSR reads are held until the bench grants them.
   always @(posedge clk) begin
      if (!rst_n) begin
         ack    <= 1'b0;
         cnt    <= 0;
         in_cyc <= 1'b0;
      end else begin
         ack <= 1'b0;
         if (stb && !ack) begin
            if (!in_cyc) begin
               in_cyc <= 1'b1;
               cap    <= {we, adr, wdat};
            end else if (!cyc || cap !== {we, adr, wdat}) begin
               stab_err <= stab_err + 1;
            end
            if (cnt >= ws && (we || adr != 3'd5 || served < grants)) begin
               ack    <= 1'b1;
               cnt    <= 0;
               in_cyc <= 1'b0;
               rdat   <= (adr == 3'd5) ? lsr_val : rbr_val;
               log_q.push_back(txn_t'({we, adr, we ? wdat : ((adr == 3'd5) ? lsr_val : rbr_val)}));
               if (!we && adr == 3'd5) served <= served + 1;
            end else begin
               cnt <= cnt + 1;
            end
         end
      end
   end

   int   txr_cnt = 0, txr_bad = 0;
   logic txr_prev = 1'b0;
   always @(negedge clk) begin
      if (tx_ready === 1'b1) begin
         txr_cnt <= txr_cnt + 1;
         if (init_done !== 1'b1 || txr_prev) txr_bad <= txr_bad + 1;
      end
      txr_prev <= tx_ready;
   end

   int         checks = 0, errors = 0, txr_exp = 0;
   logic       rxv_m = 1'b0, ovr_m = 1'b0;
   logic [7:0] rx_exp = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [25:0] outs();
      return {cyc, stb, we, adr, wdat, tx_ready, rx_valid, rx_data, init_done, overrun};
   endfunction

   task automatic expect_txn(input string tag, input logic we_e, input logic [2:0] a, input logic [7:0] d);
      txn_t t;
      int   n = 0;
      while (log_q.size() == 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (log_q.size() == 0) begin
         check({tag, "_timeout"}, 32'(log_q.size()), 32'd1);
      end else begin
         t = log_q.pop_front();
         check(tag, 32'({t.we, t.adr, t.dat}), 32'({we_e, a, d}));
      end
   endtask

   task automatic wait_stall();
      int   n = 0;
      logic s;
      s = (stb === 1'b1 && we === 1'b0 && adr === 3'd5 && ack === 1'b0 && served == grants);
      while (!s && n < 400) begin
         @(negedge clk);
         n++;
         s = (stb === 1'b1 && we === 1'b0 && adr === 3'd5 && ack === 1'b0 && served == grants);
      end
      if (!s) check("poll_stall_timeout", 32'(s), 32'd1);
   endtask

   // One poll round: the model decides from the LSR rules what must follow.
   task automatic step(input logic [7:0] lsr, input logic txv, input logic [7:0] txd,
                       input logic [7:0] rbr, input logic consume);
      wait_stall();
      if (consume && rxv_m) begin
         rx_ready = 1'b1;
         @(negedge clk);
         rx_ready = 1'b0;
         rxv_m    = 1'b0;
         check("rx_consume", 32'(rx_valid), 32'd0);
      end
      lsr_val  = lsr;
      tx_valid = txv;
      tx_data  = txd;
      rbr_val  = rbr;
      grants++;
      expect_txn("poll", 1'b0, 3'd5, lsr);
      if (lsr[1]) ovr_m = 1'b1;
      if (lsr[0] && !rxv_m) begin
         expect_txn("rbr_read", 1'b0, 3'd0, rbr);
         rxv_m  = 1'b1;
         rx_exp = rbr;
      end else if (lsr[5] && txv) begin
         expect_txn("thr_write", 1'b1, 3'd0, txd);
         txr_exp++;
      end
      wait_stall();
      check("no_extra_txn", 32'(log_q.size()), 32'd0);
      if (rxv_m) check("rx_stream", 32'({rx_valid, rx_data}), 32'({1'b1, rx_exp}));
      else       check("rx_valid_low", 32'(rx_valid), 32'd0);
      check("overrun", 32'(overrun), 32'(ovr_m));
      check("tx_ready_pulses", 32'(txr_cnt), 32'(txr_exp));
   endtask

   task automatic run_init();
      logic [10:0] exp_w [6];
      exp_w[0] = {3'd3, C_LCR | 8'h80};
      exp_w[1] = {3'd0, C_DIV[7:0]};
      exp_w[2] = {3'd1, C_DIV[15:8]};
      exp_w[3] = {3'd3, C_LCR & 8'h7F};
      exp_w[4] = {3'd2, C_FCR};
      exp_w[5] = {3'd1, 8'h00};
      for (int i = 0; i < 6; i++)
         expect_txn($sformatf("init_wr%0d", i), 1'b1, exp_w[i][10:8], exp_w[i][7:0]);
      check("init_done_early", 32'(init_done), 32'd0);
      @(negedge clk);
      check("init_done", 32'(init_done), 32'd1);
   endtask

   initial begin
      int n;
      rst_n    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'(outs()), 32'd0);
      check("sel_const", 32'(sel), 32'hF);
      rst_n = 1'b1;

      // Init sequence, then idle polling and basic TX
      run_init();
      repeat (3) step(8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      step(8'h20, 1'b1, 8'h41, 8'h00, 1'b0);
      step(8'h20, 1'b0, 8'h41, 8'h00, 1'b0);

      // RX takes priority over TX; TX follows on the next poll
      step(8'h61, 1'b1, 8'h77, 8'h5A, 1'b0);
      step(8'h61, 1'b1, 8'h77, 8'h5A, 1'b0);

      // Back-pressured RX: a single read until consumed
      step(8'h01, 1'b0, 8'h00, 8'h33, 1'b0);
      step(8'h01, 1'b0, 8'h00, 8'h34, 1'b0);
      step(8'h01, 1'b0, 8'h00, 8'h35, 1'b1);

      for (int i = 0; i < 30; i++) begin
         ws = $urandom_range(0, 2);
         step(8'($urandom) & 8'hFD, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      end

      // Five wait states per ack
      ws = 5;
      for (int i = 0; i < 6; i++)
         step(8'($urandom) & 8'hFD, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      step(8'h21, 1'b1, 8'hC3, 8'h9E, 1'b1);
      step(8'h21, 1'b1, 8'hC4, 8'h9F, 1'b0);
      check("bus_stable", 32'(stab_err), 32'd0);

      // Reset in the middle of a THR write
      step(8'h01, 1'b0, 8'h00, 8'hD2, 1'b1);
      wait_stall();
      lsr_val  = 8'h20;
      tx_valid = 1'b1;
      tx_data  = 8'hE7;
      grants++;
      txr_exp++;
      expect_txn("poll_pre_reset", 1'b0, 3'd5, 8'h20);
      n = 0;
      while (!(stb === 1'b1 && we === 1'b1 && adr === 3'd0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("thr_write_started", 32'({stb, we, adr}), 32'({1'b1, 1'b1, 3'd0}));
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_outputs", 32'(outs()), 32'd0);
      @(negedge clk);
      log_q.delete();
      rxv_m    = 1'b0;
      ovr_m    = 1'b0;
      tx_valid = 1'b0;
      rst_n    = 1'b1;
      run_init();
      check("tx_ready_pulses_reset", 32'(txr_cnt), 32'(txr_exp));

      // Overrun flag is sticky
      step(8'h03, 1'b0, 8'h00, 8'h11, 1'b0);
      step(8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
      step(8'h20, 1'b1, 8'h5C, 8'h00, 1'b0);

      check("bus_stable_final", 32'(stab_err), 32'd0);
      check("tx_ready_shape", 32'(txr_bad), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart16550_host.md
Name: uart16550_host

Overview:
- Wishbone master (initiator) that drives the uart16550 register slave from the host side.
- After reset it runs a fixed init sequence: line control, baud divisor, FIFO control, IER.
- It then polls LSR and moves bytes between two valid/ready byte streams and the UART's THR/RBR.
- Lets fabric logic with no CPU use the UART directly; it sits between the stream logic and the uart16550 slave port.

Parameters:
DIVISOR, 16'd27, baud divisor written to DLL/DLM (50 MHz / (16*115200)).
LCR_VAL, 8'h03, line control after init (8N1); bit 7 is forced 0 in the final write.
FCR_VAL, 8'hC7, FIFO control (enable, clear RX/TX FIFOs, 14-byte trigger).

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, synchronous, active-low
wbm_adr_o  out  3  register address
wbm_dat_o  out  8  write data
wbm_dat_i  in  8  read data
wbm_we_o  out  1  write enable
wbm_stb_o  out  1  strobe
wbm_cyc_o  out  1  cycle
wbm_sel_o  out  4  byte select, constant 4'hF
wbm_ack_i  in  1  acknowledge
tx_data_i  in  8  byte to transmit
tx_valid_i  in  1  tx byte valid
tx_ready_o  out  1  tx byte accepted (valid&ready = transfer)
rx_data_o  out  8  received byte
rx_valid_o  out  1  rx byte valid
rx_ready_i  in  1  rx consumer ready
init_done_o  out  1  init sequence complete
rx_overrun_o  out  1  sticky: LSR.OE seen

Behaviour:
- Reset (wb_rst_i=0 at posedge):
  - All outputs go to 0 except wbm_sel_o=4'hF.
  - State returns to INIT step 0.
  - Any in-flight bus cycle is abandoned (cyc/stb low the next cycle) and the rx buffer is cleared.
- Bus rules:
  - One outstanding cycle at a time.
  - cyc=stb=1 with adr/dat/we stable until the first cycle wbm_ack_i=1.
  - In the ack cycle the master samples wbm_dat_i; cyc/stb deassert on the following edge, for at least one idle cycle between transfers.
  - No timeout: the master waits indefinitely for ack.
- Register map (addresses):
  - 0: RBR/THR/DLL
  - 1: IER/DLM
  - 2: FCR
  - 3: LCR
  - 5: LSR
- INIT writes, in order:
  1. adr3 = LCR_VAL|8'h80
  2. adr0 = DIVISOR[7:0]
  3. adr1 = DIVISOR[15:8]
  4. adr3 = LCR_VAL&8'h7F
  5. adr2 = FCR_VAL
  6. adr1 = 8'h00
- init_done_o goes to 1 on the edge after the 6th ack and stays 1 until reset.
- States: INIT -> POLL (read adr5) -> DECIDE -> {RD_RBR | TX_ACCEPT -> WR_THR} -> POLL.
- DECIDE, evaluated on the LSR value latched at the POLL ack:
  - LSR[1]=1: set rx_overrun_o (sticky until reset).
  - Else-if priority, RX first: LSR[0]=1 and rx_valid_o=0 -> RD_RBR.
  - Else LSR[5]=1 and tx_valid_i=1 -> TX_ACCEPT.
  - Else -> POLL.
- RD_RBR: read adr0. On ack, rx_data_o<=wbm_dat_i and rx_valid_o<=1.
- rx_valid_o and rx_data_o hold until a cycle with rx_ready_i=1; rx_valid_o clears on that edge.
- An RBR read is never issued while rx_valid_o=1, so no received byte is lost in this block.
- TX_ACCEPT: exactly one cycle.
  - tx_ready_o=1 and tx_data_i is latched.
  - The source must hold tx_valid_i/tx_data_i stable until ready (it is only sampled here).
  - tx_ready_o is 0 in every other state.
- WR_THR: write the latched byte to adr0, then return to POLL.
- Only one THR write per LSR poll, so the TX FIFO is never overfilled.
- No stream activity occurs before init_done_o=1.
- Reset mid-operation restarts INIT from step 1.

Test Plan:
1. Slave model acks 1 cycle after stb; release reset with DIVISOR=27 -> exactly 6 writes:
   - (3,83), (0,1B), (1,00), (3,03), (2,C7), (1,00)
   - then init_done_o=1, then continuous reads of adr5.
2. LSR returns 8'h20 with tx_valid_i=1, tx_data_i=8'h41 -> one tx_ready_o pulse, then a write (adr0, 8'h41); with tx_valid_i=0 there is no THR write.
3. LSR returns 8'h61 and RBR returns 8'h5A, with tx_valid_i=1 -> RBR read occurs first, rx_data_o=8'h5A, rx_valid_o=1; the THR write follows on the next poll.
4. rx_ready_i held 0 with LSR=8'h01 repeatedly -> exactly one RBR read; after rx_ready_i=1 for one cycle, rx_valid_o clears and the next read occurs.
5. Slave inserts 5 wait states on each ack -> adr/dat/we/stb are stable throughout every wait; sequence and data are unchanged.
6. Assert wb_rst_i=0 mid WR_THR, then LSR=8'h03 after re-init:
   - cyc/stb low the next cycle; init restarts at (3,83); rx_valid_o=0.
   - After re-init, LSR=8'h03 -> rx_overrun_o=1 and it remains 1.
